draw_square: RTL and testbench
==============================

// Module: draw_square
// PURPOSE
// - Consumer end of the square-picker stream: takes one (x, colour) square request, rasterizes it into
//   per-pixel VGA adapter writes (x, y, colour, plot).
// - Sits between pick_square and the VGA adapter; one request = one SIDE x SIDE square on the note row.
// PARAMETERS
// - SIDE    4     square edge length in pixels (1..8); pitch between squares stays 5
// - ROW_Y   56    y-coordinate of the square's top row (7-bit screen, 0..119)
// - X_MAX   160   screen width; pixels with x >= X_MAX are suppressed
// PORTS
// - clock       in   1  system clock
// - reset       in   1  synchronous, active-high reset
// - req_valid   in   1  request present on req_x/req_colour
// - req_x       in   8  square origin x (left column)
// - req_colour  in   3  square fill colour (RGB, 3'b100 red, 3'b000 black)
// - req_ready   out  1  block idle, will accept a request this cycle
// - vga_x       out  8  pixel x to VGA adapter
// - vga_y       out  7  pixel y to VGA adapter
// - vga_colour  out  3  pixel colour to VGA adapter
// - plot        out  1  write-enable to VGA adapter, one pixel per high cycle
// - done        out  1  one-cycle pulse after the last pixel of a square
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, plot=0, done=0, vga_x=0, vga_y=0, vga_colour=0, counters=0.
// - Handshake: transfer when req_valid && req_ready on rising clock; req_x/req_colour latched then;
//   inputs ignored while req_ready=0 (no queueing, no overwrite of a square in progress).
// - FSM: IDLE -(transfer)-> DRAW -(last pixel)-> DONE -> IDLE. DONE lasts exactly one cycle (done=1).
// - DRAW: col/row counters (3-bit each) scan row-major, col fastest: (0,0),(1,0)..(SIDE-1,SIDE-1).
// - All outputs registered: transfer at cycle N -> first plot at N+1; SIDE*SIDE consecutive plot cycles;
//   done at N+1+SIDE*SIDE; req_ready=1 again at N+2+SIDE*SIDE. Back-to-back request accepted that cycle.
// - vga_x = latched_x + col (8-bit add); vga_y = ROW_Y + row (7-bit add).
// - Clipping: if latched_x + col >= X_MAX or the 8-bit add carries out, plot=0 for that pixel but scan
//   timing unchanged (latency fixed regardless of position).
// - plot=0 in IDLE and DONE; vga_* hold last values outside DRAW.
// - Reset asserted mid-DRAW: next cycle is reset state; partial square is not completed, done not pulsed.
// CONFIGURATION
// - SQUARE_BORDER_EN defined: perimeter pixels (col or row == 0 or SIDE-1) drawn 3'b111 white, interior
//   in latched colour; when latched colour is black, whole square drawn black (erase leaves no frame).
// - Undefined: every pixel drawn in latched colour. Timing identical in both builds.
// STRUCTURE
// - Shared package/include: colour constants (RED 3'b100, BLACK 3'b000, WHITE 3'b111), SCREEN_W 160,
//   SCREEN_H 120, NOTE_PITCH 5, coordinate widths (X 8, Y 7, COLOUR 3).
// - One sub-module: square_scan_counter (col/row counter with enable, sync clear, last-pixel flag).
// - Top holds FSM, request latch, address adders, clip compare, output registers.
// TESTING
// - Reset: hold reset 3 cycles -> req_ready=1, plot=0, done=0, vga_x=0, vga_y=0 every cycle.
// - Single square: req_x=10, colour=100 -> 16 plot cycles, x 10..13 per row, y 56..59, colour 100,
//   done at transfer+17, req_ready high at transfer+18.
// - Backpressure: new request (x=20) held valid during DRAW -> ignored until req_ready, then drawn at x=20;
//   first square's pixels unaffected.
// - Clip: req_x=158 -> plot only for x=158,159 (8 pixels), 16 scan cycles, done at transfer+17.
// - Reset mid-DRAW after 5 pixels -> plot=0 next cycle, no done pulse, req_ready=1, next square drawn fully.
// - SQUARE_BORDER_EN build, colour=100 -> 12 perimeter pixels 111, 4 interior 100; colour=000 -> all 000.

Source files
------------

// File: rtl/draw_square_pkg.sv
// rtl/draw_square_pkg.sv - shared constants, state type and helpers for the square rasterizer
package draw_square_pkg;

  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int COLOUR_W   = 3;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int NOTE_PITCH = 5;

  localparam logic [COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for a pixel on the outer ring of a square whose last index is 'last'
  function automatic logic on_border(input logic [2:0] col, input logic [2:0] row,
                                     input logic [2:0] last);
    return (col == 3'd0) || (row == 3'd0) || (col == last) || (row == last);
  endfunction

endpackage

// File: rtl/square_scan_counter.sv
// rtl/square_scan_counter.sv - row-major col/row scan counter with sync clear and last-pixel flag
module square_scan_counter
  import draw_square_pkg::*;
#(
  parameter int SIDE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [2:0] col_o,
  output logic [2:0] row_o,
  output logic       last_o
);

  localparam logic [2:0] LAST = 3'(SIDE - 1);

  logic [2:0] col_q;
  logic [2:0] row_q;

  // Column advances every enabled cycle; row advances when the column wraps
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      col_q <= 3'd0;
      row_q <= 3'd0;
    end else if (en_i) begin
      if (col_q == LAST) begin
        col_q <= 3'd0;
        row_q <= (row_q == LAST) ? 3'd0 : row_q + 3'd1;
      end else begin
        col_q <= col_q + 3'd1;
      end
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == LAST) && (row_q == LAST);

endmodule

// File: rtl/draw_square.sv
// rtl/draw_square.sv - rasterizes one (x, colour) request into SIDExSIDE VGA pixel writes; option SQUARE_BORDER_EN
module draw_square
  import draw_square_pkg::*;
#(
  parameter int SIDE  = 4,
  parameter int ROW_Y = 56,
  parameter int X_MAX = SCREEN_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [X_W-1:0]      req_x,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic                req_ready,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                done
);

  localparam logic [2:0] LAST = 3'(SIDE - 1);

  state_e              state_q;
  logic [X_W-1:0]      x_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                req_ready_q;
  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;
  logic                plot_q;
  logic                done_q;

  logic [2:0]          col;
  logic [2:0]          row;
  logic                last_pix;
  logic                xfer;
  logic [X_W:0]        sum_x_d;
  logic [X_W-1:0]      pix_x_d;
  logic [Y_W-1:0]      pix_y_d;
  logic [COLOUR_W-1:0] pix_colour_d;
  logic                clip_d;

  assign xfer = (state_q == ST_IDLE) && req_ready_q && req_valid;

  square_scan_counter #(
    .SIDE (SIDE)
  ) u_scan (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (xfer),
    .en_i   (state_q == ST_DRAW),
    .col_o  (col),
    .row_o  (row),
    .last_o (last_pix)
  );

  // Pixel address, clip decision and fill colour for the current scan position
  always_comb begin
    sum_x_d = {1'b0, x_q} + {{(X_W - 2){1'b0}}, col};
    pix_x_d = sum_x_d[X_W-1:0];
    pix_y_d = 7'(ROW_Y) + {4'b0000, row};
    // The 9-bit compare also catches carry-out of the 8-bit add
    clip_d  = (sum_x_d >= 9'(X_MAX));
`ifdef SQUARE_BORDER_EN
    // Erasing in black must not leave a white frame behind
    if ((colour_q != BLACK) && on_border(col, row, LAST)) begin
      pix_colour_d = WHITE;
    end else begin
      pix_colour_d = colour_q;
    end
`else
    pix_colour_d = colour_q;
`endif
  end

  // Control FSM with request latch and registered VGA outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      colour_q     <= '0;
      req_ready_q  <= 1'b1;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (xfer) begin
            x_q         <= req_x;
            colour_q    <= req_colour;
            req_ready_q <= 1'b0;
            state_q     <= ST_DRAW;
          end else begin
            // Ready rises one cycle after the done pulse has been shown
            req_ready_q <= 1'b1;
          end
        end
        ST_DRAW: begin
          vga_x_q      <= pix_x_d;
          vga_y_q      <= pix_y_d;
          vga_colour_q <= pix_colour_d;
          plot_q       <= ~clip_d;
          if (last_pix) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          plot_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          plot_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign done       = done_q;

endmodule

// File: tb/tb_draw_square.sv
// tb/tb_draw_square.sv - directed self-checking bench for draw_square
module tb_draw_square;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_x;
  logic [2:0] req_colour;
  logic       req_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       done;

  int total = 0;
  int bad   = 0;

  draw_square dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_colour (req_colour),
    .req_ready  (req_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input logic [2:0] c, input int col, input int row);
`ifdef SQUARE_BORDER_EN
    if (c != 3'b000 && (col == 0 || row == 0 || col == 3 || row == 3)) return 3'b111;
`endif
    return c;
  endfunction

  // Issue a request at a negedge where req_ready is high and check the whole square.
  // With hold set, req_valid stays high carrying (nx, nc) while the square is drawn.
  task automatic run_square(input logic [7:0] x, input logic [2:0] c, input logic hold,
                            input logic [7:0] nx, input logic [2:0] nc, input int exp_plots);
    int nplot;
    int sx;
    nplot = 0;
    check("pre_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_x      = x;
    req_colour = c;
    @(posedge clock);
    @(negedge clock);
    if (hold) begin
      req_x      = nx;
      req_colour = nc;
    end else begin
      req_valid  = 1'b0;
    end
    check("xfer_ready_low", req_ready, 0);
    check("xfer_plot_low", plot, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      sx = int'(x) + (k % 4);
      check("pix_plot", plot, (sx < 160) ? 1 : 0);
      check("pix_x", vga_x, sx & 8'hff);
      check("pix_y", vga_y, 56 + (k / 4));
      check("pix_done", done, 0);
      check("pix_ready", req_ready, 0);
      if (plot === 1'b1) begin
        nplot++;
        check("pix_colour", vga_colour, exp_colour(c, k % 4, k / 4));
      end
    end
    @(negedge clock);
    check("done_pulse", done, 1);
    check("done_plot", plot, 0);
    check("done_ready", req_ready, 0);
    check("hold_x", vga_x, (int'(x) + 3) & 8'hff);
    @(negedge clock);
    check("post_done", done, 0);
    check("post_ready", req_ready, 1);
    check("plot_count", nplot, exp_plots);
  endtask

  initial begin
    int ndone;
    int nplot;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_x      = 8'd0;
    req_colour = 3'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_ready", req_ready, 1);
      check("rst_plot", plot, 0);
      check("rst_done", done, 0);
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_y", vga_y, 0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("idle_ready", req_ready, 1);

    // Single square with a second request held pending during the draw
    run_square(8'd10, 3'b100, 1'b1, 8'd20, 3'b010, 16);
    // The pending request is accepted once ready returns
    run_square(8'd20, 3'b010, 1'b0, 8'd0, 3'b000, 16);
    // Right-edge clip: only x=158,159 plotted
    run_square(8'd158, 3'b100, 1'b0, 8'd0, 3'b000, 8);
    // Carry-out of the 8-bit add is also clipped
    run_square(8'd254, 3'b100, 1'b0, 8'd0, 3'b000, 0);

    // Reset during DRAW after 5 pixels
    req_valid  = 1'b1;
    req_x      = 8'd40;
    req_colour = 3'b100;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    nplot = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (plot === 1'b1) nplot++;
    end
    check("mid_plots", nplot, 5);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_plot", plot, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_vga_x", vga_x, 0);
    reset = 1'b0;
    ndone = 0;
    nplot = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
      if (plot === 1'b1) nplot++;
    end
    check("mid_no_done", ndone, 0);
    check("mid_no_plot", nplot, 0);
    check("mid_idle_ready", req_ready, 1);

    // Full square after the aborted one, then an erase in black
    run_square(8'd30, 3'b100, 1'b0, 8'd0, 3'b000, 16);
    run_square(8'd30, 3'b000, 1'b0, 8'd0, 3'b000, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
